// File: rtl/core_pkg.sv
// Shared types and select encodings for the multi-cycle core control path.
package core_pkg;

  `include "opcodes.svh"

  localparam int unsigned STATE_W  = 3;
  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned SEL_W    = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_TRAP    = 3'd6
  } state_t;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  localparam logic [SEL_W-1:0] A_RS1    = 2'd0;
  localparam logic [SEL_W-1:0] A_OLD_PC = 2'd1;
  localparam logic [SEL_W-1:0] A_ZERO   = 2'd2;

  localparam logic [SEL_W-1:0] B_RS2    = 2'd0;
  localparam logic [SEL_W-1:0] B_IMM    = 2'd1;
  localparam logic [SEL_W-1:0] B_FOUR   = 2'd2;

  localparam logic [SEL_W-1:0] WB_ALU   = 2'd0;
  localparam logic [SEL_W-1:0] WB_MEM   = 2'd1;
  localparam logic [SEL_W-1:0] WB_PC    = 2'd2;

  localparam logic PC_PLUS4 = 1'b0;
  localparam logic PC_ALU   = 1'b1;

  localparam logic ADDR_PC  = 1'b0;
  localparam logic ADDR_ALU = 1'b1;

  function automatic logic opcode_known(input logic [6:0] op);
    return (op == OPC_LUI)    || (op == OPC_AUIPC)  || (op == OPC_JAL)   ||
           (op == OPC_JALR)   || (op == OPC_BRANCH) || (op == OPC_LOAD)  ||
           (op == OPC_STORE)  || (op == OPC_OP_IMM) || (op == OPC_OP);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Unified memory port request/acknowledge handshake.
interface multicycle_ctrl_if;
  logic req;
  logic we;
  logic addr_sel;
  logic ack;

  modport master (output req, output we, output addr_sel, input ack);
  modport slave  (input req, input we, input addr_sel, output ack);
endinterface

// File: rtl/alu_ctrl.sv
// ALU operation decode from IR fields; ADD whenever the ALU is not doing arithmetic for R/I-type.
module alu_ctrl
  import core_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  state_t     state,
  output alu_op_t    alu_op
);

  logic is_op;
  logic is_op_imm;

  assign is_op     = (opcode == OPC_OP);
  assign is_op_imm = (opcode == OPC_OP_IMM);

  // funct7_5 is an immediate bit for I-type, so only shifts-right and R-type ADD/SUB look at it
  always_comb begin
    alu_op = ALU_ADD;
    if ((state == ST_EXECUTE) && (is_op || is_op_imm)) begin
      case (funct3)
        3'b000: alu_op = (is_op && funct7_5) ? ALU_SUB : ALU_ADD;
        3'b001: alu_op = ALU_SLL;
        3'b010: alu_op = ALU_SLT;
        3'b011: alu_op = ALU_SLTU;
        3'b100: alu_op = ALU_XOR;
        3'b101: alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
        3'b110: alu_op = ALU_OR;
        3'b111: alu_op = ALU_AND;
        default: alu_op = ALU_ADD;
      endcase
    end
  end

endmodule

// File: rtl/opcodes.svh
// RV32I base opcode constants, shared by the control FSM and the immediate generator.
`ifndef OPCODES_SVH
`define OPCODES_SVH

localparam logic [6:0] OPC_LUI    = 7'b0110111;
localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
localparam logic [6:0] OPC_JAL    = 7'b1101111;
localparam logic [6:0] OPC_JALR   = 7'b1100111;
localparam logic [6:0] OPC_BRANCH = 7'b1100011;
localparam logic [6:0] OPC_LOAD   = 7'b0000011;
localparam logic [6:0] OPC_STORE  = 7'b0100011;
localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
localparam logic [6:0] OPC_OP     = 7'b0110011;

`endif

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: fetch/decode/execute/mem/writeback over a shared ALU and memory port.
// Optional MULTICYCLE_ILLEGAL_TRAP_EN: unknown opcodes park the FSM in TRAP with o_illegal set.
module multicycle_ctrl
  import core_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [6:0]           i_opcode,
  input  logic [2:0]           i_funct3,
  input  logic                 i_funct7_5,
  input  logic                 i_branch_taken,
  multicycle_ctrl_if.master    mem,
  output logic                 o_ir_we,
  output logic                 o_pc_we,
  output logic                 o_pc_src,
  output logic [SEL_W-1:0]     o_alu_a_sel,
  output logic [SEL_W-1:0]     o_alu_b_sel,
  output logic [ALU_OP_W-1:0]  o_alu_op,
  output logic [SEL_W-1:0]     o_wb_sel,
  output logic                 o_reg_we,
  output logic                 o_illegal,
  output logic [STATE_W-1:0]   o_state
);

  state_t  state_q;
  state_t  state_d;
  alu_op_t alu_op;
  logic    is_store;
  logic    is_jump;

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  localparam state_t UNKNOWN_NEXT = ST_TRAP;
  assign o_illegal = (state_q == ST_TRAP);
`else
  localparam state_t UNKNOWN_NEXT = ST_FETCH;
  assign o_illegal = 1'b0;
`endif

  assign is_store = (i_opcode == OPC_STORE);
  assign is_jump  = (i_opcode == OPC_JAL) || (i_opcode == OPC_JALR);

  alu_ctrl u_alu_ctrl (
    .opcode   (i_opcode),
    .funct3   (i_funct3),
    .funct7_5 (i_funct7_5),
    .state    (state_q),
    .alu_op   (alu_op)
  );

  assign o_alu_op = alu_op;
  assign o_state  = state_q;

  // Reset forces IDLE, which drops every enable including an in-flight mem request
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    mem.req      = 1'b0;
    mem.we       = 1'b0;
    mem.addr_sel = ADDR_PC;
    o_ir_we      = 1'b0;
    o_pc_we      = 1'b0;
    o_pc_src     = PC_PLUS4;
    o_alu_a_sel  = A_RS1;
    o_alu_b_sel  = B_RS2;
    o_wb_sel     = WB_ALU;
    o_reg_we     = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_FETCH;

      ST_FETCH: begin
        mem.req = 1'b1;
        if (mem.ack) begin
          o_ir_we = 1'b1;
          o_pc_we = 1'b1;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: state_d = opcode_known(i_opcode) ? ST_EXECUTE : UNKNOWN_NEXT;

      ST_EXECUTE: begin
        case (i_opcode)
          OPC_OP: begin
            o_alu_b_sel = B_RS2;
            state_d     = ST_WB;
          end
          OPC_OP_IMM: begin
            o_alu_b_sel = B_IMM;
            state_d     = ST_WB;
          end
          OPC_LOAD, OPC_STORE: begin
            o_alu_b_sel = B_IMM;
            state_d     = ST_MEM;
          end
          OPC_BRANCH: begin
            o_alu_a_sel = A_OLD_PC;
            o_alu_b_sel = B_IMM;
            o_pc_we     = i_branch_taken;
            o_pc_src    = PC_ALU;
            state_d     = ST_FETCH;
          end
          OPC_JAL, OPC_JALR: begin
            o_alu_a_sel = (i_opcode == OPC_JAL) ? A_OLD_PC : A_RS1;
            o_alu_b_sel = B_IMM;
            o_pc_we     = 1'b1;
            o_pc_src    = PC_ALU;
            state_d     = ST_WB;
          end
          OPC_LUI: begin
            o_alu_a_sel = A_ZERO;
            o_alu_b_sel = B_IMM;
            state_d     = ST_WB;
          end
          OPC_AUIPC: begin
            o_alu_a_sel = A_OLD_PC;
            o_alu_b_sel = B_IMM;
            state_d     = ST_WB;
          end
          default: state_d = ST_FETCH;
        endcase
      end

      ST_MEM: begin
        mem.req      = 1'b1;
        mem.addr_sel = ADDR_ALU;
        mem.we       = is_store;
        if (mem.ack) state_d = is_store ? ST_FETCH : ST_WB;
      end

      ST_WB: begin
        o_reg_we = 1'b1;
        if (i_opcode == OPC_LOAD) o_wb_sel = WB_MEM;
        else if (is_jump)         o_wb_sel = WB_PC;
        state_d = ST_FETCH;
      end

      ST_TRAP: state_d = ST_TRAP;

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected state/controls queued, then replayed.
module tb_multicycle_ctrl;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic        taken;
  logic        ir_we, pc_we, pc_src, reg_we, illegal;
  logic [1:0]  a_sel, b_sel, wb_sel;
  logic [3:0]  alu_op;
  logic [2:0]  state;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        ack;
    logic        taken;
    logic [2:0]  st;
    logic [17:0] ctrl;
  } step_t;

  step_t sb[$];

  multicycle_ctrl_if mem ();

  multicycle_ctrl dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_opcode       (opcode),
    .i_funct3       (funct3),
    .i_funct7_5     (funct7_5),
    .i_branch_taken (taken),
    .mem            (mem),
    .o_ir_we        (ir_we),
    .o_pc_we        (pc_we),
    .o_pc_src       (pc_src),
    .o_alu_a_sel    (a_sel),
    .o_alu_b_sel    (b_sel),
    .o_alu_op       (alu_op),
    .o_wb_sel       (wb_sel),
    .o_reg_we       (reg_we),
    .o_illegal      (illegal),
    .o_state        (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {req, we, addr_sel, ir_we, pc_we, pc_src, a_sel, b_sel, alu_op, wb_sel, reg_we, illegal}
  function automatic logic [17:0] mk(input logic rq, input logic w, input logic asl,
                                     input logic ir, input logic pw, input logic ps,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [3:0] op, input logic [1:0] wb,
                                     input logic rw, input logic il);
    return {rq, w, asl, ir, pw, ps, a, b, op, wb, rw, il};
  endfunction

  function automatic logic [17:0] observed();
    return {mem.req, mem.we, mem.addr_sel, ir_we, pc_we, pc_src,
            a_sel, b_sel, alu_op, wb_sel, reg_we, illegal};
  endfunction

  task automatic push(input logic ack, input logic tk, input state_t st, input logic [17:0] ctrl);
    sb.push_back('{ack: ack, taken: tk, st: st, ctrl: ctrl});
  endtask

  task automatic push_fetch(input int waits);
    for (int i = 0; i < waits; i++) push(1'b0, 1'b0, ST_FETCH, mk(1,0,0,0,0,0,2'd0,2'd0,4'd0,2'd0,0,0));
    push(1'b1, 1'b0, ST_FETCH, mk(1,0,0,1,1,0,2'd0,2'd0,4'd0,2'd0,0,0));
  endtask

  task automatic push_decode(input logic late_ack);
    push(late_ack, 1'b0, ST_DECODE, 18'd0);
  endtask

  task automatic push_exec(input logic tk, input logic pw, input logic ps,
                           input logic [1:0] a, input logic [1:0] b, input alu_op_t op);
    push(1'b0, tk, ST_EXECUTE, mk(0,0,0,0,pw,ps,a,b,op,2'd0,0,0));
  endtask

  task automatic push_wb(input logic [1:0] wb);
    push(1'b0, 1'b0, ST_WB, mk(0,0,0,0,0,0,2'd0,2'd0,4'd0,wb,1,0));
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    opcode = op; funct3 = f3; funct7_5 = f7;
  endtask

  // Replay queued steps: drive inputs on the falling edge, compare 1ns later
  task automatic run(input string name);
    step_t s;
    int    idx = 0;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      mem.ack = s.ack;
      taken   = s.taken;
      #1;
      check($sformatf("%s[%0d].state", name, idx), 32'(state), 32'(s.st));
      check($sformatf("%s[%0d].ctrl", name, idx), 32'(observed()), 32'(s.ctrl));
      idx++;
      @(negedge clk);
    end
    mem.ack = 1'b0;
    taken   = 1'b0;
  endtask

  task automatic reset_pulse(input string name);
    mem.ack = 1'b0;
    rst_n   = 1'b0;
    #1;
    check({name, ".rst_state"}, 32'(state), 32'(ST_IDLE));
    check({name, ".rst_ctrl"}, 32'(observed()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    mem.ack = 1'b0;
    taken   = 1'b0;
    set_instr(7'h33, 3'd0, 1'b0);
    #2;
    check("reset.state", 32'(state), 32'(ST_IDLE));
    check("reset.ctrl", 32'(observed()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD x3,x1,x2 (0x002081B3), zero-wait fetch
    set_instr(7'h33, 3'd0, 1'b0);
    push(1'b0, 1'b0, ST_IDLE, 18'd0);
    push_fetch(0); push_decode(1'b0); push_exec(0, 0, 0, 2'd0, 2'd0, ALU_ADD); push_wb(2'd0);
    run("add");

    // SUB with a stray ack in DECODE that must be ignored
    set_instr(7'h33, 3'd0, 1'b1);
    push_fetch(0); push_decode(1'b1); push_exec(0, 0, 0, 2'd0, 2'd0, ALU_SUB); push_wb(2'd0);
    run("sub");

    set_instr(7'h33, 3'd3, 1'b0);
    push_fetch(1); push_decode(1'b0); push_exec(0, 0, 0, 2'd0, 2'd0, ALU_SLTU); push_wb(2'd0);
    run("sltu");

    set_instr(7'h13, 3'd5, 1'b1);
    push_fetch(0); push_decode(1'b0); push_exec(0, 0, 0, 2'd0, 2'd1, ALU_SRA); push_wb(2'd0);
    run("srai");

    // ADDI with imm bit 30 set stays ADD
    set_instr(7'h13, 3'd0, 1'b1);
    push_fetch(0); push_decode(1'b0); push_exec(0, 0, 0, 2'd0, 2'd1, ALU_ADD); push_wb(2'd0);
    run("addi");

    // LW, 3 wait cycles on both fetch and data access: 11 cycles total
    set_instr(7'h03, 3'd2, 1'b0);
    push_fetch(3); push_decode(1'b0); push_exec(0, 0, 0, 2'd0, 2'd1, ALU_ADD);
    for (int i = 0; i < 3; i++) push(1'b0, 1'b0, ST_MEM, mk(1,0,1,0,0,0,2'd0,2'd0,4'd0,2'd0,0,0));
    push(1'b1, 1'b0, ST_MEM, mk(1,0,1,0,0,0,2'd0,2'd0,4'd0,2'd0,0,0));
    push_wb(2'd1);
    check("lw.len", 32'(sb.size()), 32'd11);
    run("lw");

    set_instr(7'h23, 3'd2, 1'b0);
    push_fetch(0); push_decode(1'b0); push_exec(0, 0, 0, 2'd0, 2'd1, ALU_ADD);
    push(1'b1, 1'b0, ST_MEM, mk(1,1,1,0,0,0,2'd0,2'd0,4'd0,2'd0,0,0));
    run("sw");

    set_instr(7'h63, 3'd0, 1'b0);
    push_fetch(0); push_decode(1'b0); push_exec(1, 1, 1, 2'd1, 2'd1, ALU_ADD);
    run("beq_t");
    push_fetch(0); push_decode(1'b0); push_exec(0, 0, 1, 2'd1, 2'd1, ALU_ADD);
    run("beq_nt");

    set_instr(7'h67, 3'd0, 1'b0);
    push_fetch(0); push_decode(1'b0); push_exec(0, 1, 1, 2'd0, 2'd1, ALU_ADD); push_wb(2'd2);
    run("jalr");

    set_instr(7'h6F, 3'd0, 1'b0);
    push_fetch(0); push_decode(1'b0); push_exec(0, 1, 1, 2'd1, 2'd1, ALU_ADD); push_wb(2'd2);
    run("jal");

    set_instr(7'h37, 3'd5, 1'b1);
    push_fetch(0); push_decode(1'b0); push_exec(0, 0, 0, 2'd2, 2'd1, ALU_ADD); push_wb(2'd0);
    run("lui");

    set_instr(7'h17, 3'd0, 1'b0);
    push_fetch(0); push_decode(1'b0); push_exec(0, 0, 0, 2'd1, 2'd1, ALU_ADD); push_wb(2'd0);
    run("auipc");

    // Unknown opcode 0x7F
    set_instr(7'h7F, 3'd0, 1'b0);
    push_fetch(0); push_decode(1'b0);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    push(1'b0, 1'b0, ST_TRAP, mk(0,0,0,0,0,0,2'd0,2'd0,4'd0,2'd0,0,1));
    push(1'b1, 1'b0, ST_TRAP, mk(0,0,0,0,0,0,2'd0,2'd0,4'd0,2'd0,0,1));
    push(1'b0, 1'b0, ST_TRAP, mk(0,0,0,0,0,0,2'd0,2'd0,4'd0,2'd0,0,1));
`else
    push(1'b0, 1'b0, ST_FETCH, mk(1,0,0,0,0,0,2'd0,2'd0,4'd0,2'd0,0,0));
`endif
    run("illegal");
    reset_pulse("illegal");

    // Reset asserted mid-cycle while a store waits in MEM
    set_instr(7'h23, 3'd2, 1'b0);
    push(1'b0, 1'b0, ST_IDLE, 18'd0);
    push_fetch(0); push_decode(1'b0); push_exec(0, 0, 0, 2'd0, 2'd1, ALU_ADD);
    push(1'b0, 1'b0, ST_MEM, mk(1,1,1,0,0,0,2'd0,2'd0,4'd0,2'd0,0,0));
    push(1'b0, 1'b0, ST_MEM, mk(1,1,1,0,0,0,2'd0,2'd0,4'd0,2'd0,0,0));
    run("sw_wait");
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst.req", 32'(mem.req), 32'd0);
    check("midrst.state", 32'(state), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    push(1'b0, 1'b0, ST_IDLE, 18'd0);
    push(1'b0, 1'b0, ST_FETCH, mk(1,0,0,0,0,0,2'd0,2'd0,4'd0,2'd0,0,0));
    run("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
